// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: a Moore FSM that sequences fetch/decode/execute/memory/writeback.
// Latency: 3-5 cycles per instruction, plus one cycle for each memory wait state.
// Backpressure: holds in FETCH/MEMRD/MEMWR while ready=0, keeping its strobes asserted.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-low reset (forces FETCH, all outputs 0)
//   op, funct         instruction register fields IR[31:26] / IR[5:0]
//   zero              ALU zero flag, used for beq/bne in BRANCH
//   ready             shared memory completes its access this cycle
//   pc_en .. pc_src   datapath mux selects and write enables
//   alu_control       ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt), upper bits 0
//   state             current state code for debug
//   illegal           one-cycle pulse when an instruction cannot be decoded
module multicycle_controller #(
  parameter bit          ENABLE_BNE       = 1'b1,
  parameter bit          ENABLE_IMM_LOGIC = 1'b1,
  parameter int unsigned ALUCTL_W         = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                ready,
  output logic                pc_en,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                ext_zero,
  output logic [1:0]          pc_src,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic [3:0]          state,
  output logic                illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11,
    S_ILL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     cur_state;
  state_t     nxt_state;

  logic       is_rtype;
  logic       is_lw;
  logic       is_sw;
  logic       is_beq;
  logic       is_bne;
  logic       is_addi;
  logic       is_andi;
  logic       is_ori;
  logic       is_slti;
  logic       is_j;
  logic       is_imm;
  logic       funct_ok;
  logic [2:0] funct_ctl;
  logic [2:0] imm_ctl;

  logic       pc_write;
  logic       branch_eq;
  logic       branch_ne;
  logic [2:0] ctl;

  // Opcode decode; disabled instruction groups simply never match and fall to ILL.
  assign is_rtype = (op == OP_RTYPE);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_bne   = ENABLE_BNE && (op == OP_BNE);
  assign is_addi  = (op == OP_ADDI);
  assign is_andi  = ENABLE_IMM_LOGIC && (op == OP_ANDI);
  assign is_ori   = ENABLE_IMM_LOGIC && (op == OP_ORI);
  assign is_slti  = ENABLE_IMM_LOGIC && (op == OP_SLTI);
  assign is_j     = (op == OP_J);
  assign is_imm   = is_addi | is_andi | is_ori | is_slti;

  always_comb begin
    funct_ok  = 1'b1;
    funct_ctl = ALU_AND;
    case (funct)
      6'b100000: funct_ctl = ALU_ADD;
      6'b100010: funct_ctl = ALU_SUB;
      6'b100100: funct_ctl = ALU_AND;
      6'b100101: funct_ctl = ALU_OR;
      6'b101010: funct_ctl = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Shared by IMMEX and IMMWB so the ALU result stays valid during writeback.
  always_comb begin
    imm_ctl = ALU_ADD;
    if (is_andi)      imm_ctl = ALU_AND;
    else if (is_ori)  imm_ctl = ALU_OR;
    else if (is_slti) imm_ctl = ALU_SLT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur_state <= S_FETCH;
    else      cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_FETCH:  if (ready) nxt_state = S_DECODE;
      S_DECODE: begin
        if (is_rtype)               nxt_state = S_EXEC;
        else if (is_lw || is_sw)    nxt_state = S_MEMADR;
        else if (is_beq || is_bne)  nxt_state = S_BRANCH;
        else if (is_imm)            nxt_state = S_IMMEX;
        else if (is_j)              nxt_state = S_JUMP;
        else                        nxt_state = S_ILL;
      end
      S_MEMADR: nxt_state = is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (ready) nxt_state = S_MEMWB;
      S_MEMWB:  nxt_state = S_FETCH;
      S_MEMWR:  if (ready) nxt_state = S_FETCH;
      S_EXEC:   nxt_state = funct_ok ? S_ALUWB : S_ILL;
      S_ALUWB:  nxt_state = S_FETCH;
      S_BRANCH: nxt_state = S_FETCH;
      S_IMMEX:  nxt_state = S_IMMWB;
      S_IMMWB:  nxt_state = S_FETCH;
      S_JUMP:   nxt_state = S_FETCH;
      S_ILL:    nxt_state = S_FETCH;
      default:  nxt_state = S_FETCH;
    endcase
  end

  // Outputs are gated by rst directly so that asserting reset kills every
  // strobe in the same instant, not at the next clock edge.
  always_comb begin
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_zero   = 1'b0;
    pc_src     = 2'b00;
    illegal    = 1'b0;
    pc_write   = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    ctl        = 3'b000;
    if (rst) begin
      case (cur_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ctl       = ALU_ADD;
          // Loading IR and PC only on the completing cycle prevents a
          // double increment while the memory is stalling.
          ir_write  = ready;
          pc_write  = ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          ctl       = ALU_ADD;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ctl       = ALU_ADD;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          ctl       = funct_ctl;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          ctl       = ALU_SUB;
          pc_src    = 2'b01;
          branch_eq = is_beq;
          branch_ne = is_bne;
        end
        S_IMMEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ctl       = imm_ctl;
          ext_zero  = is_andi | is_ori;
        end
        S_IMMWB: begin
          reg_write = 1'b1;
          ctl       = imm_ctl;
          ext_zero  = is_andi | is_ori;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        S_ILL: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign pc_en = pc_write | (branch_eq & zero) | (branch_ne & ~zero);
  assign state = cur_state;

  always_comb begin
    alu_control      = '0;
    alu_control[2:0] = ctl;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: default build (dut a) and a
// build with bne/andi/ori/slti disabled and a 4-bit alu_control (dut b).
// Expected behaviour comes from an instruction-level step plan plus per-step outputs.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       ready = 1'b0;

  logic       a_pc_en, a_iord, a_mem_read, a_mem_write, a_ir_write, a_reg_dst;
  logic       a_mem_to_reg, a_reg_write, a_alu_src_a, a_ext_zero, a_illegal;
  logic [1:0] a_alu_src_b, a_pc_src;
  logic [2:0] a_alu_control;
  logic [3:0] a_state;

  logic       b_pc_en, b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_dst;
  logic       b_mem_to_reg, b_reg_write, b_alu_src_a, b_ext_zero, b_illegal;
  logic [1:0] b_alu_src_b, b_pc_src;
  logic [3:0] b_alu_control;
  logic [3:0] b_state;

  multicycle_controller dut_a (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .ready(ready),
    .pc_en(a_pc_en), .iord(a_iord), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .ir_write(a_ir_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
    .reg_write(a_reg_write), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
    .ext_zero(a_ext_zero), .pc_src(a_pc_src), .alu_control(a_alu_control),
    .state(a_state), .illegal(a_illegal)
  );

  multicycle_controller #(.ENABLE_BNE(1'b0), .ENABLE_IMM_LOGIC(1'b0), .ALUCTL_W(4)) dut_b (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .ready(ready),
    .pc_en(b_pc_en), .iord(b_iord), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .ir_write(b_ir_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
    .reg_write(b_reg_write), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .ext_zero(b_ext_zero), .pc_src(b_pc_src), .alu_control(b_alu_control),
    .state(b_state), .illegal(b_illegal)
  );

  always #5 clk = ~clk;

  // {state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
  //  reg_write, alu_src_a, alu_src_b, ext_zero, pc_src, alu_control(4), illegal}
  logic [22:0] act_a, act_b;
  assign act_a = {a_state, a_pc_en, a_iord, a_mem_read, a_mem_write, a_ir_write, a_reg_dst,
                  a_mem_to_reg, a_reg_write, a_alu_src_a, a_alu_src_b, a_ext_zero, a_pc_src,
                  1'b0, a_alu_control, a_illegal};
  assign act_b = {b_state, b_pc_en, b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_dst,
                  b_mem_to_reg, b_reg_write, b_alu_src_a, b_alu_src_b, b_ext_zero, b_pc_src,
                  b_alu_control, b_illegal};

  int tests = 0;
  int fails = 0;
  int plan_q[$];

  // Which steps an instruction walks through, from its class alone.
  function automatic void build_plan(input logic [5:0] o, input logic [5:0] f,
                                     input bit en_bne, input bit en_imm);
    bit rf_ok;
    rf_ok = (f == 6'd32) || (f == 6'd34) || (f == 6'd36) || (f == 6'd37) || (f == 6'd42);
    plan_q = {};
    if (o == 6'd0)       plan_q = rf_ok ? '{0, 1, 6, 7} : '{0, 1, 6, 12};
    else if (o == 6'd35) plan_q = '{0, 1, 2, 3, 4};
    else if (o == 6'd43) plan_q = '{0, 1, 2, 5};
    else if (o == 6'd4 || (o == 6'd5 && en_bne)) plan_q = '{0, 1, 8};
    else if (o == 6'd8 || (en_imm && (o == 6'd12 || o == 6'd13 || o == 6'd10)))
      plan_q = '{0, 1, 9, 10};
    else if (o == 6'd2)  plan_q = '{0, 1, 11};
    else                 plan_q = '{0, 1, 12};
  endfunction

  // Outputs expected while the controller is in a given step.
  function automatic logic [22:0] model_out(input int step, input logic [5:0] o,
                                            input logic [5:0] f, input logic z, input logic r);
    logic pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, sa, ez, ill;
    logic [1:0] sb, ps;
    logic [3:0] ctl;
    {pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, sa, ez, ill} = '0;
    sb = 2'b00; ps = 2'b00; ctl = 4'd0;
    case (step)
      0: begin mrd = 1; sb = 2'b01; ctl = 4'd2; irw = r; pc_en = r; end
      1: begin sb = 2'b11; ctl = 4'd2; end
      2: begin sa = 1; sb = 2'b10; ctl = 4'd2; end
      3: begin mrd = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mwr = 1; iord = 1; end
      6: begin
        sa = 1;
        if (f == 6'd32) ctl = 4'd2;
        else if (f == 6'd34) ctl = 4'd6;
        else if (f == 6'd37) ctl = 4'd1;
        else if (f == 6'd42) ctl = 4'd7;
      end
      7: begin rw = 1; rdst = 1; end
      8: begin sa = 1; ctl = 4'd6; ps = 2'b01; pc_en = (o == 6'd4) ? z : ~z; end
      9, 10: begin
        if (step == 9) begin sa = 1; sb = 2'b10; end
        else rw = 1;
        ctl = (o == 6'd12) ? 4'd0 : (o == 6'd13) ? 4'd1 : (o == 6'd10) ? 4'd7 : 4'd2;
        ez  = (o == 6'd12) || (o == 6'd13);
      end
      11: begin pc_en = 1; ps = 2'b10; end
      12: ill = 1;
      default: ;
    endcase
    return {4'(step), pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, sa, sb, ez, ps, ctl, ill};
  endfunction

  // Entered and left just after a falling edge with the DUT in FETCH.
  // rpat bit n is ready in the n-th cycle of the instruction (1 beyond bit 31).
  task automatic run_instr(input bit use_b, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input logic [31:0] rpat, input string name);
    int idx = 0;
    int cyc = 0;
    logic [22:0] exp_v, got;
    op = o; funct = f; zero = z;
    build_plan(o, f, !use_b, !use_b);
    while (idx < plan_q.size() && cyc < 64) begin
      ready = (cyc < 32) ? rpat[cyc] : 1'b1;
      #2;
      exp_v = model_out(plan_q[idx], o, f, z, ready);
      got   = use_b ? act_b : act_a;
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL %s cycle %0d step %0d: got %h expected %h", name, cyc, plan_q[idx],
                 got, exp_v);
      end
      if (!(plan_q[idx] == 0 || plan_q[idx] == 3 || plan_q[idx] == 5) || ready) idx++;
      cyc++;
      @(negedge clk);
    end
    if (idx < plan_q.size()) begin
      tests++; fails++;
      $display("FAIL %s timeout: reached step index %0d of %0d", name, idx, plan_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      ready = 1'(urandom_bit());
      op = 6'($urandom);
      #2;
      tests++;
      if (act_a !== 23'd0 || act_b !== 23'd0) begin
        fails++;
        $display("FAIL reset_outputs: got a=%h b=%h expected 0", act_a, act_b);
      end
      @(negedge clk);
    end
    rst = 1'b1;
  endtask

  function automatic int urandom_bit();
    return int'($urandom_range(0, 1));
  endfunction

  task automatic test_reset();
    do_reset();
    do_reset();
  endtask

  task automatic test_lw_seq();
    do_reset();
    run_instr(0, 6'd35, 6'd0, 1'b0, 32'hFFFF_FFFF, "lw_seq");
    run_instr(0, 6'd0, 6'd32, 1'b0, 32'hFFFF_FFFF, "add_after_lw");
  endtask

  task automatic test_fetch_wait();
    do_reset();
    run_instr(0, 6'd0, 6'd34, 1'b0, 32'hFFFF_FFF8, "fetch_wait");
    run_instr(0, 6'd35, 6'd0, 1'b0, 32'hFFFF_FFE7, "memrd_wait");
    run_instr(0, 6'd43, 6'd0, 1'b0, 32'hFFFF_FFC7, "memwr_wait");
  endtask

  task automatic test_branch();
    do_reset();
    run_instr(0, 6'd4, 6'd0, 1'b1, 32'hFFFF_FFFF, "beq_taken");
    run_instr(0, 6'd4, 6'd0, 1'b0, 32'hFFFF_FFFF, "beq_not_taken");
    run_instr(0, 6'd5, 6'd0, 1'b0, 32'hFFFF_FFFF, "bne_taken");
    run_instr(0, 6'd5, 6'd0, 1'b1, 32'hFFFF_FFFF, "bne_not_taken");
  endtask

  task automatic test_rtype();
    logic [5:0] fl [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    do_reset();
    for (int i = 0; i < 5; i++) run_instr(0, 6'd0, fl[i], 1'b0, 32'hFFFF_FFFF, "rtype");
    run_instr(0, 6'd0, 6'd0, 1'b0, 32'hFFFF_FFFF, "rtype_bad_funct");
    run_instr(0, 6'd0, 6'd42, 1'b0, 32'hFFFF_FFFF, "slt_after_illegal");
  endtask

  task automatic test_imm();
    do_reset();
    run_instr(0, 6'd13, 6'd0, 1'b0, 32'hFFFF_FFFF, "ori");
    run_instr(0, 6'd12, 6'd0, 1'b0, 32'hFFFF_FFFF, "andi");
    run_instr(0, 6'd10, 6'd0, 1'b0, 32'hFFFF_FFFF, "slti");
    run_instr(0, 6'd8,  6'd0, 1'b0, 32'hFFFF_FFFF, "addi");
    run_instr(0, 6'd63, 6'd0, 1'b0, 32'hFFFF_FFFF, "bad_op");
    run_instr(0, 6'd2,  6'd0, 1'b0, 32'hFFFF_FFFF, "j_after_bad_op");
  endtask

  task automatic test_disabled();
    do_reset();
    run_instr(1, 6'd13, 6'd0, 1'b0, 32'hFFFF_FFFF, "dis_ori");
    run_instr(1, 6'd5,  6'd0, 1'b0, 32'hFFFF_FFFF, "dis_bne");
    run_instr(1, 6'd12, 6'd0, 1'b0, 32'hFFFF_FFFF, "dis_andi");
    run_instr(1, 6'd10, 6'd0, 1'b0, 32'hFFFF_FFFF, "dis_slti");
    run_instr(1, 6'd8,  6'd0, 1'b0, 32'hFFFF_FFFF, "dis_addi");
    run_instr(1, 6'd0,  6'd42, 1'b0, 32'hFFFF_FFFF, "dis_slt");
    run_instr(1, 6'd4,  6'd0, 1'b1, 32'hFFFF_FFFF, "dis_beq");
  endtask

  task automatic test_async_reset();
    do_reset();
    op = 6'd43; funct = 6'd0; ready = 1'b1;
    repeat (3) @(negedge clk);
    ready = 1'b0;
    #2;
    tests++;
    if (a_state !== 4'd5 || a_mem_write !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_memwr: got state=%0d mem_write=%b expected 5/1", a_state,
               a_mem_write);
    end
    #1 rst = 1'b0;
    #1;
    tests++;
    if (act_a !== 23'd0) begin
      fails++;
      $display("FAIL async_reset: got %h expected 0", act_a);
    end
    @(negedge clk);
    rst = 1'b1;
    run_instr(0, 6'd2, 6'd0, 1'b0, 32'hFFFF_FFFF, "j_after_reset");
    run_instr(0, 6'd43, 6'd0, 1'b0, 32'hFFFF_FFFF, "sw_after_j");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [10] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd12, 6'd13, 6'd10, 6'd2};
    logic [5:0] fl [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    logic [5:0] o, f;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      int k = int'($urandom_range(0, 11));
      o = (k < 10) ? ops[k] : 6'($urandom);
      f = ($urandom_range(0, 3) != 0) ? fl[$urandom_range(0, 4)] : 6'($urandom);
      run_instr(0, o, f, 1'(urandom_bit()), $urandom | $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_lw_seq();
    test_fetch_wait();
    test_branch();
    test_rtype();
    test_imm();
    test_disabled();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
